// File: rtl/stream_to_frame_buf.sv
// Pixel-stream to block-RAM frame writer with optional ping-pong buffering.
// Capture stalls in WAIT_BUF while the target buffer is still owned by the consumer.
module stream_to_frame_buf #(
   parameter int D          = 16,
   parameter int N          = 17,
   parameter int IMG_W      = 128,
   parameter int IMG_H      = 128,
   parameter int ROW_STRIDE = 128,
   parameter int BASE_ADDR  = 0,
   parameter int BUF_SIZE   = 16384,
   parameter int PINGPONG   = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         continuous,
   input  logic         pipe_read_ack,
   input  logic [D-1:0] pipe_read_data,
   output logic         pipe_read_req,
   output logic         ena,
   output logic         wea,
   output logic [N-1:0] addr,
   output logic [D-1:0] data,
   output logic         frame_done,
   output logic         done_buf,
   output logic [1:0]   buf_full,
   input  logic         buf_release,
   input  logic         buf_release_idx,
   output logic         busy
);

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [N-1:0] BASE0  = N'(BASE_ADDR);
   localparam logic [N-1:0] BASE1  = N'(BASE_ADDR + BUF_SIZE);
   localparam logic [N-1:0] STRIDE = N'(ROW_STRIDE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_WAIT_BUF,
      S_WRITE,
      S_DONE
   } state_t;

   state_t         r_state;
   state_t         w_nextState;
   logic [XW-1:0]  r_x;
   logic [YW-1:0]  r_y;
   logic [N-1:0]   r_rowAddr;
   logic           r_wrBuf;
   logic [1:0]     r_bufFull;
   logic [1:0]     w_bufFullNext;
   logic           r_doneBuf;
   logic           r_ena;
   logic           r_wea;
   logic [N-1:0]   r_addr;
   logic [D-1:0]   r_data;
   logic           w_xfer;
   logic           w_lastX;
   logic           w_lastY;
   logic           w_lastPix;
   logic [N-1:0]   w_bufBase;
   logic [N-1:0]   w_pixAddr;

   assign w_xfer    = (r_state == S_WRITE) && pipe_read_ack;
   assign w_lastX   = (r_x == XW'(IMG_W - 1));
   assign w_lastY   = (r_y == YW'(IMG_H - 1));
   assign w_lastPix = w_xfer && w_lastX && w_lastY;
   assign w_bufBase = r_wrBuf ? BASE1 : BASE0;
   // Row base is accumulated rather than multiplied; the sum wraps at N bits.
   assign w_pixAddr = w_bufBase + r_rowAddr + N'(r_x);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:     if (start || continuous) w_nextState = S_CHECK;
         S_CHECK:    w_nextState = r_bufFull[r_wrBuf] ? S_WAIT_BUF : S_WRITE;
         S_WAIT_BUF: if (!r_bufFull[r_wrBuf]) w_nextState = S_WRITE;
         S_WRITE:    if (w_lastPix) w_nextState = S_DONE;
         S_DONE:     w_nextState = continuous ? S_CHECK : S_IDLE;
         default:    w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || (r_state != S_WRITE)) begin
         r_x       <= '0;
         r_y       <= '0;
         r_rowAddr <= '0;
      end else if (w_xfer) begin
         if (w_lastX) begin
            r_x <= '0;
            if (w_lastY) begin
               r_y       <= '0;
               r_rowAddr <= '0;
            end else begin
               r_y       <= r_y + 1'b1;
               r_rowAddr <= r_rowAddr + STRIDE;
            end
         end else begin
            r_x <= r_x + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ena  <= 1'b0;
         r_wea  <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_ena <= w_xfer;
         r_wea <= w_xfer;
         if (w_xfer) begin
            r_addr <= w_pixAddr;
            r_data <= pipe_read_data;
         end
      end
   end

   // Completion is applied after release so a same-cycle collision leaves the buffer full.
   always_comb begin
      w_bufFullNext = r_bufFull;
      if (buf_release && ((PINGPONG != 0) || !buf_release_idx)) begin
         w_bufFullNext[buf_release_idx] = 1'b0;
      end
      if (w_lastPix) begin
         w_bufFullNext[r_wrBuf] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bufFull <= 2'b00;
         r_doneBuf <= 1'b0;
         r_wrBuf   <= 1'b0;
      end else begin
         r_bufFull <= w_bufFullNext;
         if (w_lastPix) begin
            r_doneBuf <= r_wrBuf;
         end
         if ((r_state == S_DONE) && (PINGPONG != 0)) begin
            r_wrBuf <= ~r_wrBuf;
         end
      end
   end

   assign pipe_read_req = (r_state == S_WRITE);
   assign frame_done    = (r_state == S_DONE);
   assign busy          = (r_state != S_IDLE);
   assign ena           = r_ena;
   assign wea           = r_wea;
   assign addr          = r_addr;
   assign data          = r_data;
   assign done_buf      = r_doneBuf;
   assign buf_full      = r_bufFull;

endmodule
